// File: rtl/fp_mul_round_normalize.sv
// Post-multiply normalize/round/pack stage of the floating-point multiplier.
// Two-stage valid/ready pipeline: stage 1 normalizes and classifies, stage 2 rounds and packs.
module fp_mul_round_normalize #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int BIAS  = 15
) (
   input  logic                       clk_in,
   input  logic                       reset_in,
   input  logic                       in_valid_in,
   output logic                       in_ready_out,
   input  logic [2*(MAN_W+1)-1:0]     product_in,
   input  logic [EXP_W-1:0]           exp_a_in,
   input  logic [EXP_W-1:0]           exp_b_in,
   input  logic                       sign_a_in,
   input  logic                       sign_b_in,
   input  logic                       nan_in,
   output logic                       out_valid_out,
   input  logic                       out_ready_in,
   output logic [EXP_W+MAN_W:0]       result_out,
   output logic [2:0]                 flags_out
);

   localparam int M  = MAN_W + 1;
   localparam int PW = 2 * M;
   localparam int EW = EXP_W + 2;
   localparam logic [EW-1:0] BIAS_E = EW'(BIAS);
   localparam logic [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);

   logic s1_v, s2_v, s1_adv, s2_adv;

   assign s2_adv        = !s2_v || out_ready_in;
   assign s1_adv        = !s1_v || s2_adv;
   assign in_ready_out  = s1_adv;
   assign out_valid_out = s2_v;

   // stage 1: exponent sum, normalization and operand classification
   logic              a_max, b_max, a_zero, b_zero;
   logic [EW-1:0]     e_sum, n1_e;
   logic [MAN_W-1:0]  n1_frac;
   logic              n1_g, n1_s;

   assign a_max  = &exp_a_in;
   assign b_max  = &exp_b_in;
   assign a_zero = ~|exp_a_in;
   assign b_zero = ~|exp_b_in;

   always_comb begin
      e_sum = EW'(exp_a_in) + EW'(exp_b_in) - BIAS_E;
      if (product_in[PW-1]) begin
         n1_frac = product_in[PW-2 -: MAN_W];
         n1_g    = product_in[PW-2-MAN_W];
         n1_s    = |product_in[PW-3-MAN_W:0];
         n1_e    = e_sum + EW'(1);
      end else begin
         n1_frac = product_in[PW-3 -: MAN_W];
         n1_g    = product_in[PW-3-MAN_W];
         n1_s    = |product_in[PW-4-MAN_W:0];
         n1_e    = e_sum;
      end
   end

   logic              s1_sign, s1_g, s1_s, s1_nan, s1_inf, s1_zero;
   logic [EW-1:0]     s1_e;
   logic [MAN_W-1:0]  s1_frac;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         s1_v <= 1'b0;
      end else if (s1_adv) begin
         s1_v <= in_valid_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (s1_adv && in_valid_in) begin
         s1_sign <= sign_a_in ^ sign_b_in;
         s1_e    <= n1_e;
         s1_frac <= n1_frac;
         s1_g    <= n1_g;
         s1_s    <= n1_s;
         s1_nan  <= nan_in || (a_zero && b_max) || (a_max && b_zero);
         s1_inf  <= a_max || b_max;
         s1_zero <= a_zero || b_zero;
      end
   end

   // stage 2: round to nearest-even, then resolve specials and range
   logic              round_up, carry;
   logic [MAN_W-1:0]  r_frac;
   logic [EW-1:0]     r_e;
   logic              ovf, unf;
   logic [EXP_W+MAN_W:0] n2_res;
   logic [2:0]        n2_flags;

   always_comb begin
      round_up        = s1_g && (s1_s || s1_frac[0]);
      {carry, r_frac} = {1'b0, s1_frac} + (MAN_W+1)'(round_up);
      r_e             = s1_e + EW'(carry);
      ovf             = $signed(r_e) >= $signed(EMAX_E);
      unf             = r_e[EW-1] || (r_e == '0);
      n2_res          = '0;
      n2_flags        = 3'b000;
      if (s1_nan) begin
         n2_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      end else if (s1_inf) begin
         n2_res = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (s1_zero) begin
         n2_res = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
      end else if (ovf) begin
         n2_res   = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         n2_flags = 3'b101;
      end else if (unf) begin
         n2_res   = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
         n2_flags = 3'b011;
      end else begin
         n2_res   = {s1_sign, r_e[EXP_W-1:0], r_frac};
         n2_flags = {2'b00, s1_g || s1_s};
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         s2_v       <= 1'b0;
         result_out <= '0;
         flags_out  <= 3'b000;
      end else if (s2_adv) begin
         s2_v <= s1_v;
         if (s1_v) begin
            result_out <= n2_res;
            flags_out  <= n2_flags;
         end
      end
   end

endmodule
